dac_arbiter: RTL
================

DAC_ARBITER -- requirements
Module: dac_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one dac_interface, range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: WAIT-state cycle limit, used only with DAC_ARB_TIMEOUT_EN.
REQ-003 sclk  input  1: single clock; all logic on rising edge.
REQ-004 n_reset  input  1: asynchronous, active-low reset.
REQ-005 req  input  N_REQ: per-requester transfer request, level, held until matching ack.
REQ-006 req_data  input  N_REQ*8: per-requester DAC word; requester i occupies bits [8i+7:8i].
REQ-007 ack  output  N_REQ: one-cycle completion pulse to the served requester.
REQ-008 busy  output  1: high in every state except IDLE.
REQ-009 dac_start  output  1: one-cycle start pulse to dac_interface.
REQ-010 dac_data  output  8: word to dac_interface.
REQ-011 dac_done  input  1: completion from dac_interface.
REQ-012 timeout_err  output  1: one-cycle pulse on watchdog abort; present only with DAC_ARB_TIMEOUT_EN.

Function
REQ-013 FSM states IDLE, START, WAIT, ACK shall be used; no other states.
REQ-014 IDLE: if any req bit is high, latch the winner index and its req_data slice and go to START; otherwise stay.
REQ-015 Winner selection shall be round-robin: search starts at (last_served+1) mod N_REQ, first high req wins.
REQ-016 START: dac_start = 1 for exactly this one cycle; go to WAIT.
REQ-017 dac_data shall equal the latched word from START through ACK and hold its value in IDLE.
REQ-018 WAIT: on dac_done = 1 go to ACK; dac_done shall be ignored in IDLE, START and ACK.
REQ-019 ACK: ack[winner] = 1 for this cycle only, last_served <= winner, go to IDLE.
REQ-020 Latency: req rising into IDLE at edge t gives dac_start high in cycle t+1; ack follows dac_done by one cycle.
REQ-021 A req withdrawn after being latched shall not abort the transfer; ack is still pulsed.
REQ-022 A requester still high after its ack shall re-arbitrate in IDLE without priority over others.
REQ-023 Request changes during START/WAIT/ACK shall not alter the latched winner or word.
REQ-024 At most one ack bit shall be high in any cycle; ack and dac_start shall never be high together.

Reset
REQ-025 On n_reset low: state IDLE, ack = 0, busy = 0, dac_start = 0, dac_data = 0, timeout_err = 0, last_served = N_REQ-1 (first search starts at index 0).
REQ-026 Reset asserted mid-transfer shall abandon the transfer with no ack issued after release.

Configuration
REQ-027 Macro DAC_ARB_TIMEOUT_EN defined: a WAIT-cycle counter cleared on entering WAIT; reaching TIMEOUT_CYCLES without dac_done forces ACK with ack[winner] and timeout_err pulsed in the same cycle.
REQ-028 Macro undefined: no counter, no timeout_err port; WAIT waits indefinitely for dac_done.

Structure
REQ-029 Package dac_pkg shall hold the FSM state enum and constant DAC_WIDTH = 8.
REQ-030 Sub-module rr_arbiter shall implement the round-robin pick from req and last_served, returning a valid flag and index.

Verification
REQ-031 Single request: req = 0001, req_data[7:0] = 8'h33, dac_done after 16 cycles -> dac_start one cycle after req, dac_data = 8'h33, ack = 0001 one cycle after dac_done.
REQ-032 Contention: req = 1111 held continuously, data 8'hA0..8'hA3 -> service order 0,1,2,3,0 and dac_data sequence A0,A1,A2,A3,A0.
REQ-033 Skip: last_served = 1, req = 1001 -> requester 3 served before 0.
REQ-034 Withdrawal: req[2] dropped during WAIT -> transfer completes, ack = 0100 pulsed once.
REQ-035 Reset mid-WAIT: n_reset low for 1 cycle -> all outputs 0 immediately, no ack, next grant goes to index 0.
REQ-036 Timeout (macro on, TIMEOUT_CYCLES = 64): dac_done held 0 -> ack and timeout_err pulse together 64 cycles after entering WAIT.

Source files
------------

// File: rtl/dac_arbiter_pkg.sv
// dac_pkg -- shared types and constants for the DAC arbiter slice.
//   dac_state_t : arbiter FSM state encoding (IDLE, START, WAIT, ACK)
//   DAC_WIDTH   : width of one DAC word
//   idx_w()     : index width for a requester count (minimum 1 bit)
// Optional feature macro used by this slice: DAC_ARB_TIMEOUT_EN.
package dac_pkg;

   localparam int DAC_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } dac_state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dac_arbiter_if.sv
// dac_arbiter_if -- requester bus plus dac_interface handshake.
//   req[N_REQ]            : per-requester level request
//   req_data[N_REQ][8]    : per-requester DAC word
//   ack[N_REQ]            : one-cycle completion pulse
//   busy                  : arbiter not idle
//   dac_start / dac_data  : start pulse and word toward dac_interface
//   dac_done              : completion from dac_interface
//   timeout_err           : watchdog abort pulse (DAC_ARB_TIMEOUT_EN only)
// Modports: slave = arbiter side, master = requesters + dac_interface side.
interface dac_arbiter_if #(
   parameter int N_REQ = 4
);
   import dac_pkg::*;

   logic [N_REQ-1:0]                req;
   logic [N_REQ-1:0][DAC_WIDTH-1:0] req_data;
   logic [N_REQ-1:0]                ack;
   logic                            busy;
   logic                            dac_start;
   logic [DAC_WIDTH-1:0]            dac_data;
   logic                            dac_done;
`ifdef DAC_ARB_TIMEOUT_EN
   logic                            timeout_err;

   modport slave  (input  req, req_data, dac_done,
                   output ack, busy, dac_start, dac_data, timeout_err);
   modport master (output req, req_data, dac_done,
                   input  ack, busy, dac_start, dac_data, timeout_err);
`else
   modport slave  (input  req, req_data, dac_done,
                   output ack, busy, dac_start, dac_data);
   modport master (output req, req_data, dac_done,
                   input  ack, busy, dac_start, dac_data);
`endif

endinterface

// File: rtl/dac_arbiter_rr_arbiter.sv
// rr_arbiter -- combinational round-robin pick.
//   req[N_REQ] : request vector
//   last       : index served most recently
//   vld        : at least one request is high
//   idx        : winner, first high req starting at (last+1) mod N_REQ
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDXW  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDXW-1:0]  last,
   output logic             vld,
   output logic [IDXW-1:0]  idx
);

   logic [IDXW-1:0] j;

   // Walk from the farthest candidate back to the nearest so the nearest
   // high request after 'last' is the final assignment and wins.
   always_comb begin
      vld = 1'b0;
      idx = '0;
      j   = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         j = IDXW'((int'(last) + k) % N_REQ);
         if (req[j]) begin
            vld = 1'b1;
            idx = j;
         end
      end
   end

endmodule

// File: rtl/dac_arbiter.sv
// dac_arbiter -- shares one dac_interface among N_REQ requesters.
//   sclk     : clock, rising edge
//   n_reset  : asynchronous active-low reset
//   bus      : dac_arbiter_if.slave (req/req_data/ack, busy,
//              dac_start/dac_data/dac_done, timeout_err)
// Parameters: N_REQ (2..8), TIMEOUT_CYCLES (WAIT limit).
// Macro DAC_ARB_TIMEOUT_EN: enables the WAIT watchdog and timeout_err.
// FSM IDLE -> START -> WAIT -> ACK -> IDLE; all outputs registered.
module dac_arbiter
   import dac_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic          sclk,
   input  logic          n_reset,
   dac_arbiter_if.slave  bus
);

   localparam int IDXW = idx_w(N_REQ);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("dac_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   dac_state_t           state;
   logic [IDXW-1:0]      winner;
   logic [IDXW-1:0]      last_served;
   logic [N_REQ-1:0]     ack_q;
   logic                 busy_q;
   logic                 start_q;
   logic [DAC_WIDTH-1:0] data_q;

   logic                 pick_vld;
   logic [IDXW-1:0]      pick_idx;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDXW  (IDXW)
   ) u_rr (
      .req  (bus.req),
      .last (last_served),
      .vld  (pick_vld),
      .idx  (pick_idx)
   );

`ifdef DAC_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt;
   logic          terr_q;
`endif

   always_ff @(posedge sclk or negedge n_reset) begin
      if (!n_reset) begin
         state       <= ST_IDLE;
         winner      <= '0;
         last_served <= IDXW'(N_REQ - 1);
         ack_q       <= '0;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         data_q      <= '0;
`ifdef DAC_ARB_TIMEOUT_EN
         wait_cnt    <= '0;
         terr_q      <= 1'b0;
`endif
      end else begin
         // pulses default low; each is raised for exactly one state
         ack_q   <= '0;
         start_q <= 1'b0;
`ifdef DAC_ARB_TIMEOUT_EN
         terr_q  <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  winner  <= pick_idx;
                  data_q  <= bus.req_data[pick_idx];
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               state <= ST_WAIT;
`ifdef DAC_ARB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            ST_WAIT: begin
               if (bus.dac_done) begin
                  ack_q <= N_REQ'(1) << winner;
                  state <= ST_ACK;
               end
`ifdef DAC_ARB_TIMEOUT_EN
               // last allowed WAIT cycle: abort with ack + error together
               else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  ack_q  <= N_REQ'(1) << winner;
                  terr_q <= 1'b1;
                  state  <= ST_ACK;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            ST_ACK: begin
               last_served <= winner;
               busy_q      <= 1'b0;
               state       <= ST_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ack       = ack_q;
   assign bus.busy      = busy_q;
   assign bus.dac_start = start_q;
   assign bus.dac_data  = data_q;
`ifdef DAC_ARB_TIMEOUT_EN
   assign bus.timeout_err = terr_q;
`endif

endmodule
